// File: rtl/dmem_pkg.sv
// Shared types and helpers for the synchronous data memory: access sizes,
// controller states, the response record and the byte-lane mask.
package dmem_pkg;

  typedef enum logic [1:0] {
    SZ_B   = 2'd0,
    SZ_H   = 2'd1,
    SZ_W   = 2'd2,
    SZ_RSV = 2'd3
  } dmem_size_t;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } dmem_state_t;

  typedef struct packed {
    logic        valid;
    logic        err;
    logic [31:0] rdata;
  } dmem_rsp_t;

  localparam dmem_rsp_t RSP_IDLE = '{valid: 1'b0, err: 1'b0, rdata: 32'd0};

  // Little-endian lane enables for an access of the given size at byte offset off.
  function automatic logic [3:0] lane_mask(input dmem_size_t size, input logic [1:0] off);
    case (size)
      SZ_B:    lane_mask = 4'b0001 << off;
      SZ_H:    lane_mask = off[1] ? 4'b1100 : 4'b0011;
      SZ_W:    lane_mask = 4'b1111;
      default: lane_mask = 4'b0000;
    endcase
  endfunction

endpackage

// File: rtl/dmem_rsp_pipe.sv
// Fixed-length response delay line; LATENCY register stages (1..4) with a
// synchronous active-low clear that drops every response in flight.
module dmem_rsp_pipe
  import dmem_pkg::*;
#(
  parameter int LATENCY = 1
) (
  input  logic      clk,
  input  logic      rst_n,
  input  dmem_rsp_t rsp_new,
  output dmem_rsp_t rsp_last
);

  dmem_rsp_t stage [LATENCY];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < LATENCY; i++) stage[i] <= RSP_IDLE;
    end else begin
      stage[0] <= rsp_new;
      for (int i = 1; i < LATENCY; i++) stage[i] <= stage[i-1];
    end
  end

  assign rsp_last = stage[LATENCY-1];

endmodule

// File: rtl/data_memory_sync.sv
// Synchronous byte-addressable data memory with a post-reset zero-fill, size
// and alignment checking, lane merge on stores and sign/zero-extended loads.
module data_memory_sync
  import dmem_pkg::*;
#(
  parameter int DEPTH   = 4000,
  parameter int ADDR_W  = 32,
  parameter int LATENCY = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output dmem_state_t       dbg_state
);

  // Handshake: a request is taken on every rising edge where req_valid and
  // req_ready are both high; req_ready depends only on state and rst_n, never
  // on req_valid. Responses have no back-pressure and pulse for one cycle.

  localparam int CNT_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(DEPTH - 1);

  logic [31:0] mem [DEPTH];

  dmem_state_t      state, state_nxt;
  logic [CNT_W-1:0] init_cnt, init_cnt_nxt;
  logic             fill_we;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= INIT;
      init_cnt <= '0;
    end else begin
      state    <= state_nxt;
      init_cnt <= init_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    init_cnt_nxt = init_cnt;
    req_ready    = 1'b0;
    fill_we      = 1'b0;
    case (state)
      INIT: begin
        fill_we      = rst_n;
        init_cnt_nxt = init_cnt + CNT_W'(1);
        if (init_cnt == LAST_IDX) begin
          state_nxt    = RUN;
          init_cnt_nxt = '0;
        end
      end
      RUN:     req_ready = rst_n;
      default: state_nxt = INIT;
    endcase
  end

  assign dbg_state = state;

  // Request decode and checking.
  dmem_size_t        size;
  logic [1:0]        off;
  logic [ADDR_W-3:0] word_idx;
  logic              in_range, misalign, err, accept, store_we;
  logic [CNT_W-1:0]  mem_idx;
  logic [3:0]        mask;

  assign size     = dmem_size_t'(req_size);
  assign off      = req_addr[1:0];
  assign word_idx = req_addr[ADDR_W-1:2];
  assign in_range = (word_idx < (ADDR_W-2)'(DEPTH));
  assign misalign = ((size == SZ_H) && off[0]) || ((size == SZ_W) && (off != 2'd0));
  assign err      = (size == SZ_RSV) || misalign || !in_range;
  assign accept   = req_valid && req_ready;
  assign store_we = accept && req_we && !err;
  assign mask     = lane_mask(size, off);
  // Out-of-range addresses are steered to word 0 so the read never leaves the array.
  assign mem_idx  = in_range ? word_idx[CNT_W-1:0] : '0;

  // Store data is pre-replicated so each enabled lane simply takes its own byte.
  logic [31:0] wrep;
  always_comb begin
    wrep = req_wdata;
    case (size)
      SZ_B:    wrep = {4{req_wdata[7:0]}};
      SZ_H:    wrep = {2{req_wdata[15:0]}};
      default: wrep = req_wdata;
    endcase
  end

  always_ff @(posedge clk) begin
    if (fill_we) begin
      mem[init_cnt] <= '0;
    end else if (store_we) begin
      for (int i = 0; i < 4; i++) begin
        if (mask[i]) mem[mem_idx][8*i +: 8] <= wrep[8*i +: 8];
      end
    end
  end

  // Load extraction from the word as it stands before this edge's write.
  logic [31:0] rd_word, ld_data;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  assign rd_word  = mem[mem_idx];
  assign byte_sel = rd_word[{off, 3'b000} +: 8];
  assign half_sel = off[1] ? rd_word[31:16] : rd_word[15:0];

  always_comb begin
    ld_data = 32'd0;
    case (size)
      SZ_B:    ld_data = req_signed ? {{24{byte_sel[7]}}, byte_sel} : {24'd0, byte_sel};
      SZ_H:    ld_data = req_signed ? {{16{half_sel[15]}}, half_sel} : {16'd0, half_sel};
      SZ_W:    ld_data = rd_word;
      default: ld_data = 32'd0;
    endcase
  end

  dmem_rsp_t rsp_new, rsp_last;

  always_comb begin
    rsp_new       = RSP_IDLE;
    rsp_new.valid = accept;
    rsp_new.err   = accept && err;
    rsp_new.rdata = (accept && !req_we && !err) ? ld_data : 32'd0;
  end

  dmem_rsp_pipe #(
    .LATENCY (LATENCY)
  ) u_rsp_pipe (
    .clk      (clk),
    .rst_n    (rst_n),
    .rsp_new  (rsp_new),
    .rsp_last (rsp_last)
  );

  assign rsp_valid = rsp_last.valid;
  assign rsp_err   = rsp_last.err;
  assign rsp_rdata = rsp_last.rdata;

endmodule

// File: tb/tb_data_memory_sync.sv
// Bench for data_memory_sync: two instances (LATENCY 1 and 3) share one
// request stream and are checked every cycle against a byte-array model.
module tb_data_memory_sync;
  import dmem_pkg::*;

  localparam int DEPTH  = 16;
  localparam int ADDR_W = 32;

  // Clock / reset
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic              req_valid  = 1'b0;
  logic              req_we     = 1'b0;
  logic [1:0]        req_size   = 2'd0;
  logic              req_signed = 1'b0;
  logic [ADDR_W-1:0] req_addr   = '0;
  logic [31:0]       req_wdata  = '0;

  logic        ready1, ready3, v1, v3, e1, e3;
  logic [31:0] d1, d3;
  dmem_state_t st1, st3;

  data_memory_sync #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .LATENCY(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(ready1),
    .req_we(req_we), .req_size(req_size), .req_signed(req_signed),
    .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(v1),
    .rsp_rdata(d1), .rsp_err(e1), .dbg_state(st1)
  );

  data_memory_sync #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .LATENCY(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(ready3),
    .req_we(req_we), .req_size(req_size), .req_signed(req_signed),
    .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(v3),
    .rsp_rdata(d3), .rsp_err(e3), .dbg_state(st3)
  );

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;
  bit chk_en      = 1'b0;

  // Scoreboard: expected responses tagged with the edge that registers them.
  typedef struct {
    int          due;
    logic        err;
    logic [31:0] rdata;
  } exp_t;
  exp_t exp_q1[$];
  exp_t exp_q3[$];

  logic [7:0] model_mem [4*DEPTH];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference behaviour: byte-addressed array, size-aligned access, range check.
  task automatic model_req(input logic we, input logic [1:0] size, input logic sgn,
                           input logic [31:0] addr, input logic [31:0] wdata,
                           output logic err, output logic [31:0] rdata);
    int nbytes;
    logic [31:0] v;
    nbytes = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
    err    = (size == 2'd3) || ((addr % nbytes) != 0) || (addr >= 32'(4*DEPTH));
    rdata  = 32'd0;
    v      = 32'd0;
    if (!err) begin
      if (we) begin
        for (int i = 0; i < nbytes; i++) model_mem[addr + i] = wdata[8*i +: 8];
      end else begin
        for (int i = 0; i < nbytes; i++) v = v | (32'(model_mem[addr + i]) << (8*i));
        if (sgn && nbytes < 4 && v[8*nbytes-1]) v = v | ~((32'd1 << (8*nbytes)) - 32'd1);
        rdata = v;
      end
    end
  endtask

  // Driver: present one request at a negedge; it is accepted at the next posedge.
  task automatic do_req(input logic we, input logic [1:0] size, input logic sgn,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        output logic err, output logic [31:0] rdata);
    @(negedge clk);
    check("req_ready", {30'd0, ready3, ready1}, 32'd3);
    req_valid  = 1'b1;
    req_we     = we;
    req_size   = size;
    req_signed = sgn;
    req_addr   = addr;
    req_wdata  = wdata;
    model_req(we, size, sgn, addr, wdata, err, rdata);
    exp_q1.push_back('{due: cyc + 1, err: err, rdata: rdata});
    exp_q3.push_back('{due: cyc + 3, err: err, rdata: rdata});
  endtask

  task automatic idle(input int n);
    @(negedge clk);
    req_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset(input int n);
    @(negedge clk);
    req_valid = 1'b0;
    rst_n     = 1'b0;
    for (int i = 0; i < 4*DEPTH; i++) model_mem[i] = 8'd0;
    repeat (n) @(negedge clk);
    check("rst_rdata", d1 | d3, 32'd0);
    check("rst_err", {30'd0, e3, e1}, 32'd0);
    rst_n = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      check("init_ready", {30'd0, ready3, ready1}, 32'd0);
      @(negedge clk);
    end
    check("run_ready", {30'd0, ready3, ready1}, 32'd3);
    check("run_state", {30'd0, 1'(st3), 1'(st1)}, 32'd3);
  endtask

  // Edge counter; a reset edge discards every response not yet registered.
  always @(posedge clk) begin
    cyc++;
    if (!rst_n) begin
      while (exp_q1.size() > 0 && exp_q1[exp_q1.size()-1].due >= cyc) void'(exp_q1.pop_back());
      while (exp_q3.size() > 0 && exp_q3[exp_q3.size()-1].due >= cyc) void'(exp_q3.pop_back());
    end
  end

  // Compare process: every cycle, each response port either matches the head
  // of its queue or must be idle.
  always @(negedge clk) begin
    if (chk_en) begin
      if (exp_q1.size() > 0 && exp_q1[0].due == cyc) begin
        check("l1_valid", {31'd0, v1}, 32'd1);
        check("l1_err", {31'd0, e1}, {31'd0, exp_q1[0].err});
        check("l1_rdata", d1, exp_q1[0].rdata);
        void'(exp_q1.pop_front());
      end else begin
        check("l1_idle", {31'd0, v1}, 32'd0);
      end
      if (exp_q3.size() > 0 && exp_q3[0].due == cyc) begin
        check("l3_valid", {31'd0, v3}, 32'd1);
        check("l3_err", {31'd0, e3}, {31'd0, exp_q3[0].err});
        check("l3_rdata", d3, exp_q3[0].rdata);
        void'(exp_q3.pop_front());
      end else begin
        check("l3_idle", {31'd0, v3}, 32'd0);
      end
    end
  end

  initial begin
    logic        err;
    logic [31:0] rd;

    repeat (2) @(negedge clk);
    chk_en = 1'b1;
    do_reset(3);

    // Zero after init
    do_req(1'b0, 2'd2, 1'b0, 32'h8, 32'h0, err, rd);
    check("pin_init_err", {31'd0, err}, 32'd0);
    check("pin_init_rdata", rd, 32'h0);

    // Word store then immediate load
    do_req(1'b1, 2'd2, 1'b0, 32'h4, 32'h00000001, err, rd);
    do_req(1'b0, 2'd2, 1'b0, 32'h4, 32'h0, err, rd);
    check("pin_word_rdata", rd, 32'h00000001);
    idle(4);

    // Sub-word merge and extension
    do_req(1'b1, 2'd2, 1'b0, 32'h10, 32'h11223344, err, rd);
    do_req(1'b1, 2'd0, 1'b0, 32'h11, 32'h000000AB, err, rd);
    do_req(1'b1, 2'd1, 1'b0, 32'h12, 32'h0000BEEF, err, rd);
    do_req(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, err, rd);
    check("pin_merge_word", rd, 32'hBEEFAB44);
    do_req(1'b0, 2'd0, 1'b1, 32'h11, 32'h0, err, rd);
    check("pin_sbyte", rd, 32'hFFFFFFAB);
    do_req(1'b0, 2'd1, 1'b0, 32'h12, 32'h0, err, rd);
    check("pin_uhalf", rd, 32'h0000BEEF);
    idle(4);

    // Error cases
    do_req(1'b0, 2'd2, 1'b0, 32'h6, 32'h0, err, rd);
    check("pin_misalign_w", {31'd0, err}, 32'd1);
    do_req(1'b1, 2'd1, 1'b0, 32'h3, 32'hFFFF, err, rd);
    check("pin_misalign_h", {31'd0, err}, 32'd1);
    do_req(1'b0, 2'd2, 1'b0, 32'h0, 32'h0, err, rd);
    check("pin_word0_clean", rd, 32'h0);
    do_req(1'b0, 2'd3, 1'b0, 32'h8, 32'h0, err, rd);
    check("pin_rsv_size", {31'd0, err}, 32'd1);
    do_req(1'b0, 2'd2, 1'b0, 32'(4*DEPTH), 32'h0, err, rd);
    check("pin_range", {31'd0, err}, 32'd1);
    idle(4);

    // Eight back-to-back requests
    do_req(1'b1, 2'd2, 1'b0, 32'h20, 32'hCAFEF00D, err, rd);
    do_req(1'b0, 2'd2, 1'b0, 32'h20, 32'h0, err, rd);
    do_req(1'b1, 2'd1, 1'b0, 32'h22, 32'h00008001, err, rd);
    do_req(1'b0, 2'd1, 1'b1, 32'h22, 32'h0, err, rd);
    check("pin_shalf", rd, 32'hFFFF8001);
    do_req(1'b0, 2'd0, 1'b0, 32'h23, 32'h0, err, rd);
    check("pin_ubyte", rd, 32'h00000080);
    do_req(1'b1, 2'd0, 1'b0, 32'h3C, 32'h1234567F, err, rd);
    do_req(1'b0, 2'd0, 1'b1, 32'h3C, 32'h0, err, rd);
    do_req(1'b0, 2'd2, 1'b0, 32'h3C, 32'h0, err, rd);
    check("pin_b2b_word", rd, 32'h0000007F);
    idle(6);

    // Reset with loads in flight, then written locations must read zero
    do_req(1'b0, 2'd2, 1'b0, 32'h4, 32'h0, err, rd);
    do_req(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, err, rd);
    do_reset(3);
    do_req(1'b0, 2'd2, 1'b0, 32'h4, 32'h0, err, rd);
    check("pin_refill_4", rd, 32'h0);
    do_req(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, err, rd);
    check("pin_refill_10", rd, 32'h0);
    idle(6);

    check("drain", 32'(exp_q1.size() + exp_q3.size()), 32'd0);
    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
